// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage of the pipelined RISC-V core.
// It runs data-memory loads/stores over a req/ack handshake, stalls the
// upstream stages while an access is outstanding, resolves the branch
// decision and feeds the MEM/WB register so that every instruction reaches
// write-back exactly once. Stall cycles push bubbles into MEM/WB.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255  // max WAIT cycles without ack (1..255)
) (
  input  logic        clk,
  input  logic        reset,          // asynchronous, active low
  // EX/MEM register
  input  logic        Zero,
  input  logic        Branch,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Regwrite,
  input  logic        MemtoReg,
  input  logic [63:0] Result,
  input  logic [63:0] ReadData2,
  input  logic [4:0]  rd,
  input  logic [63:0] sum,
  // data memory
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  // pipeline control
  output logic        stall,
  output logic        PCSrc,
  output logic [63:0] branch_target,
  output logic        err,
  // MEM/WB register
  output logic [63:0] ReadData_out,
  output logic [63:0] Result_out,
  output logic [4:0]  rd_out,
  output logic        Regwrite_out,
  output logic        MemtoReg_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter only ever reaches TIMEOUT-1 before the abort, so 8 bits suffice.
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [63:0] buf_q, buf_d;       // load data waiting for the DONE edge
  logic [63:0] wb_rdata_q, wb_rdata_d;
  logic [63:0] wb_result_q, wb_result_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic        wb_memtoreg_q, wb_memtoreg_d;

  logic memop;
  assign memop = MemRead | MemWrite;

  // Next-state, handshake and MEM/WB selection; stall/PCSrc never see mem_ack.
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    buf_d         = buf_q;
    // MEM/WB defaults to a bubble; only a non-stalled edge loads real data.
    wb_rdata_d    = '0;
    wb_result_d   = '0;
    wb_rd_d       = '0;
    wb_regwrite_d = 1'b0;
    wb_memtoreg_d = 1'b0;
    stall         = 1'b0;
    PCSrc         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (memop) begin
          stall   = 1'b1;
          state_d = S_WAIT;
          req_d   = 1'b1;
          we_d    = MemWrite;       // store wins when both flags are set
          addr_d  = Result;
          wdata_d = ReadData2;
          cnt_d   = '0;
        end else begin
          PCSrc         = Branch & Zero;
          wb_result_d   = Result;
          wb_rd_d       = rd;
          wb_regwrite_d = Regwrite;
          wb_memtoreg_d = MemtoReg;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (mem_ack) begin
          req_d   = 1'b0;
          buf_d   = we_q ? 64'd0 : mem_rdata;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == TIMEOUT_C) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            buf_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // EX/MEM still holds the memory instruction on this edge.
        wb_rdata_d    = buf_q;
        wb_result_d   = Result;
        wb_rd_d       = rd;
        wb_regwrite_d = Regwrite;
        wb_memtoreg_d = MemtoReg;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset acts immediately, even mid-access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      buf_q         <= '0;
      wb_rdata_q    <= '0;
      wb_result_q   <= '0;
      wb_rd_q       <= '0;
      wb_regwrite_q <= 1'b0;
      wb_memtoreg_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      buf_q         <= buf_d;
      wb_rdata_q    <= wb_rdata_d;
      wb_result_q   <= wb_result_d;
      wb_rd_q       <= wb_rd_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_memtoreg_q <= wb_memtoreg_d;
    end
  end

  assign mem_req       = req_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign err           = err_q;
  assign branch_target = sum;
  assign ReadData_out  = wb_rdata_q;
  assign Result_out    = wb_result_q;
  assign rd_out        = wb_rd_q;
  assign Regwrite_out  = wb_regwrite_q;
  assign MemtoReg_out  = wb_memtoreg_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed steps followed by random
// transactions, each checked against a transaction-level expectation.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        Zero, Branch, MemRead, MemWrite, Regwrite, MemtoReg;
  logic [63:0] Result, ReadData2, sum;
  logic [4:0]  rd;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        mem_req, mem_we, stall, PCSrc, err;
  logic [63:0] mem_addr, mem_wdata, branch_target;
  logic [63:0] ReadData_out, Result_out;
  logic [4:0]  rd_out;
  logic        Regwrite_out, MemtoReg_out;

  int checks = 0;
  int errors = 0;
  bit err_exp = 1'b0;   // sticky timeout flag expected by the model

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .Zero(Zero), .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
    .Regwrite(Regwrite), .MemtoReg(MemtoReg),
    .Result(Result), .ReadData2(ReadData2), .rd(rd), .sum(sum),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall(stall), .PCSrc(PCSrc), .branch_target(branch_target), .err(err),
    .ReadData_out(ReadData_out), .Result_out(Result_out), .rd_out(rd_out),
    .Regwrite_out(Regwrite_out), .MemtoReg_out(MemtoReg_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_wb_regwrite"}, 64'(Regwrite_out), 64'd0);
    chk({tag, "_wb_memtoreg"}, 64'(MemtoReg_out), 64'd0);
    chk({tag, "_wb_rd"},       64'(rd_out),       64'd0);
    chk({tag, "_wb_result"},   Result_out,        64'd0);
    chk({tag, "_wb_rdata"},    ReadData_out,      64'd0);
  endtask

  // Non-memory instruction: one cycle, MEM/WB loads on the first edge.
  task automatic alu_op(input logic br, input logic z, input logic rw, input logic m2r,
                        input logic [63:0] res, input logic [4:0] r, input logic [63:0] sm);
    Branch = br; Zero = z; MemRead = 1'b0; MemWrite = 1'b0;
    Regwrite = rw; MemtoReg = m2r; Result = res; rd = r; sum = sm;
    ReadData2 = {$urandom, $urandom};
    mem_ack = 1'($urandom);            // ignored in IDLE
    mem_rdata = {$urandom, $urandom};
    #1;
    chk("alu_stall", 64'(stall), 64'd0);
    chk("alu_pcsrc", 64'(PCSrc), 64'(br & z));
    chk("alu_target", branch_target, sm);
    chk("alu_req", 64'(mem_req), 64'd0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("alu_wb_result", Result_out, res);
    chk("alu_wb_rd", 64'(rd_out), 64'(r));
    chk("alu_wb_regwrite", 64'(Regwrite_out), 64'(rw));
    chk("alu_wb_memtoreg", 64'(MemtoReg_out), 64'(m2r));
    chk("alu_wb_rdata", ReadData_out, 64'd0);
    chk("alu_err", 64'(err), 64'(err_exp));
    $display("alu  res=%0h rd=%0d br=%0b z=%0b", res, r, br, z);
  endtask

  // Memory instruction; ack arrives on WAIT cycle d (1-based), never if d
  // is outside 1..TO, in which case the access times out after TO cycles.
  task automatic mem_op(input logic mr, input logic mw, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [63:0] rdv, input int d,
                        input logic rw, input logic m2r, input logic [4:0] r);
    bit acked = 1'b0;
    logic [63:0] exp_rd;
    Branch = 1'b1; Zero = 1'b1;         // branch must be suppressed while stalled
    MemRead = mr; MemWrite = mw; Regwrite = rw; MemtoReg = m2r;
    Result = addr; ReadData2 = wd; rd = r; sum = {$urandom, $urandom};
    mem_ack = 1'($urandom);             // ignored in IDLE
    mem_rdata = {$urandom, $urandom};
    #1;
    chk("mem_idle_stall", 64'(stall), 64'd1);
    chk("mem_idle_pcsrc", 64'(PCSrc), 64'd0);
    chk("mem_idle_req", 64'(mem_req), 64'd0);
    @(posedge clk); #1;
    for (int j = 1; j <= TO; j++) begin
      mem_ack = 1'b0;
      chk("wait_req", 64'(mem_req), 64'd1);
      chk("wait_addr", mem_addr, addr);
      chk("wait_we", 64'(mem_we), 64'(mw));
      chk("wait_wdata", mem_wdata, wd);
      chk("wait_stall", 64'(stall), 64'd1);
      chk("wait_pcsrc", 64'(PCSrc), 64'd0);
      chk_bubble("wait");
      mem_ack   = (j == d);
      mem_rdata = (j == d) ? rdv : {$urandom, $urandom};
      #1;
      chk("wait_stall_ack", 64'(stall), 64'd1);   // stall independent of ack
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (j == d) begin
        acked = 1'b1;
        break;
      end
    end
    if (!acked) err_exp = 1'b1;
    exp_rd = (acked && !mw) ? rdv : 64'd0;
    chk("done_stall", 64'(stall), 64'd0);
    chk("done_pcsrc", 64'(PCSrc), 64'd0);
    chk("done_req", 64'(mem_req), 64'd0);
    chk("done_err", 64'(err), 64'(err_exp));
    chk_bubble("done");
    mem_ack = 1'($urandom);             // ignored in DONE
    mem_rdata = {$urandom, $urandom};
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("wb_result", Result_out, addr);
    chk("wb_rd", 64'(rd_out), 64'(r));
    chk("wb_regwrite", 64'(Regwrite_out), 64'(rw));
    chk("wb_memtoreg", 64'(MemtoReg_out), 64'(m2r));
    chk("wb_rdata", ReadData_out, exp_rd);
    chk("wb_req", 64'(mem_req), 64'd0);
    chk("wb_err", 64'(err), 64'(err_exp));
    $display("mem  rd=%0b wr=%0b addr=%0h ack_cycle=%0d acked=%0b rdata=%0h",
             mr, mw, addr, d, acked, exp_rd);
  endtask

  initial begin
    reset = 1'b0;
    Zero = 0; Branch = 0; MemRead = 0; MemWrite = 0; Regwrite = 0; MemtoReg = 0;
    Result = '0; ReadData2 = '0; rd = '0; sum = '0; mem_ack = 0; mem_rdata = '0;
    #1;
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk_bubble("rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;

    // Directed steps
    alu_op(1'b0, 1'b0, 1'b1, 1'b0, 64'h10, 5'd5, 64'h0);
    mem_op(1'b1, 1'b0, 64'h100, 64'h0, 64'hDEADBEEF, 1, 1'b1, 1'b1, 5'd7);
    mem_op(1'b0, 1'b1, 64'h8, 64'h55, 64'h1234, 4, 1'b0, 1'b0, 5'd0);
    alu_op(1'b1, 1'b1, 1'b0, 1'b0, 64'h20, 5'd0, 64'h400);
    alu_op(1'b1, 1'b0, 1'b0, 1'b0, 64'h24, 5'd0, 64'h400);
    mem_op(1'b1, 1'b0, 64'h200, 64'h0, 64'hCAFE, 0, 1'b1, 1'b1, 5'd9);
    mem_op(1'b1, 1'b1, 64'h300, 64'h77, 64'hBEEF, 2, 1'b1, 1'b1, 5'd3);
    alu_op(1'b0, 1'b1, 1'b1, 1'b0, 64'h44, 5'd12, 64'h0);

    // Random transactions
    for (int t = 0; t < 40; t++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      if (kind == 0)
        alu_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               {$urandom, $urandom}, 5'($urandom), {$urandom, $urandom});
      else
        mem_op(kind != 2, kind >= 2, {$urandom, $urandom}, {$urandom, $urandom},
               {$urandom, $urandom}, int'($urandom_range(0, TO + 1)),
               1'($urandom), 1'($urandom), 5'($urandom));
    end

    // Reset mid-WAIT: everything clears without a clock edge
    Branch = 1'b0; Zero = 1'b0; MemRead = 1'b1; MemWrite = 1'b0;
    Regwrite = 1'b1; MemtoReg = 1'b1; Result = 64'h500; rd = 5'd4;
    ReadData2 = 64'h99; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_req", 64'(mem_req), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    err_exp = 1'b0;
    chk("midrst_req", 64'(mem_req), 64'd0);
    chk("midrst_we", 64'(mem_we), 64'd0);
    chk("midrst_addr", mem_addr, 64'd0);
    chk("midrst_wdata", mem_wdata, 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    chk_bubble("midrst");
    MemRead = 1'b0;
    #1;
    chk("midrst_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    $display("reset asserted mid-WAIT");
    mem_op(1'b1, 1'b0, 64'h600, 64'h0, 64'h0BAD_F00D, 2, 1'b1, 1'b1, 5'd6);
    alu_op(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 5'd0, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage controller of the pipelined RISC-V core. It consumes the EX/MEM pipeline register outputs and performs data-memory loads and stores over a req/ack handshake. It stalls upstream stages while an access is outstanding and resolves the branch decision. It also drives the MEM/WB register contents, so each instruction reaches write-back exactly once.

## Interface
- TIMEOUT, 255: maximum WAIT cycles without mem_ack before the access is abandoned (1..255).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- Zero, Branch, MemRead, MemWrite, Regwrite, MemtoReg  in  1 each  from EX/MEM register.
- Result  in  64  ALU result / memory address.
- ReadData2  in  64  store data.
- rd  in  5  destination register.
- sum  in  64  branch target.
- mem_ack  in  1  memory completion strobe.
- mem_rdata  in  64  load data, valid when mem_ack=1.
- mem_req  out  1  registered request, held until ack or timeout.
- mem_we  out  1  1 = store, 0 = load; registered.
- mem_addr, mem_wdata  out  64 each  registered address and store data.
- stall  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM.
- PCSrc  out  1  combinational branch-taken.
- branch_target  out  64  equals sum.
- err  out  1  sticky timeout flag.
- ReadData_out, Result_out  out  64 each  MEM/WB data.
- rd_out  out  5  MEM/WB destination.
- Regwrite_out, MemtoReg_out  out  1 each  MEM/WB control.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- memop = MemRead | MemWrite. When both are set, MemWrite wins: the access is a store and ReadData_out is 0.
- IDLE
  - With memop=0: stall=0, PCSrc = Branch & Zero. At the clock edge, MEM/WB loads Result, rd, Regwrite and MemtoReg; ReadData_out is loaded with 0.
  - With memop=1: stall=1, PCSrc=0. At the clock edge, latch mem_addr=Result, mem_wdata=ReadData2, mem_we=MemWrite; set mem_req=1; clear the timeout counter; go to WAIT.
- WAIT: stall=1, PCSrc=0. mem_req and the address, data and we signals are held constant.
  - Edge with mem_ack=1: mem_req is set to 0. Buffer mem_rdata when the access is a load (0 for a store). Go to DONE.
  - Edge with mem_ack=0: the counter increments. When the counter reaches TIMEOUT, mem_req is set to 0, err is set to 1, the buffer is set to 0, and the FSM goes to DONE.
- DONE: stall=0, PCSrc=0. At the clock edge, MEM/WB loads the buffer into ReadData_out together with Result, rd, Regwrite and MemtoReg. Go to IDLE. EX/MEM advances on this same edge.
- While stall=1, every edge loads a bubble into MEM/WB: Regwrite_out=0, MemtoReg_out=0, rd_out=0, ReadData_out=0, Result_out=0.
- mem_ack is ignored in IDLE and DONE.
- err is cleared only by reset.
- No arithmetic is performed on the data path; all 64-bit values pass through unchanged.

## Timing
- Reset (asynchronous, reset=0) forces state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, err=0 and all MEM/WB outputs to 0, counter=0. This takes effect immediately, including mid-WAIT, where mem_req drops without waiting for ack.
- Non-memory instruction: the MEM/WB outputs update on the first edge, so latency is 1 cycle.
- Memory instruction with ack in the first WAIT cycle: IDLE → WAIT → DONE. MEM/WB holds the result after the 3rd edge, and stall is high for 2 cycles.
- With ack arriving on WAIT cycle k (1-based), stall is high for k+1 cycles.
- mem_req rises one edge after the memop is presented and falls on the edge that samples mem_ack=1.
- Back-to-back memory instructions: DONE goes to IDLE, then a new request is issued one edge later. mem_req is therefore low for at least 2 cycles between accesses.
- stall and PCSrc are functions of state and the EX/MEM inputs only, with no dependence on mem_ack.

## Test plan
- Reset, then drive ALU op Result=0x10, rd=5, Regwrite=1 → after 1 edge, Result_out=0x10, rd_out=5, Regwrite_out=1, and stall stays 0.
- Load with Result=0x100; ack on the 1st WAIT cycle with mem_rdata=0xDEADBEEF → mem_req high for exactly 1 cycle with mem_addr=0x100 and mem_we=0; stall high for 2 cycles; ReadData_out=0xDEADBEEF after the 3rd edge; bubble in MEM/WB during the stall.
- Store with Result=0x8, ReadData2=0x55; ack delayed 4 cycles → mem_we=1, mem_wdata=0x55 held stable; stall high for 5 cycles; Regwrite_out=0 throughout.
- Branch=1, Zero=1, sum=0x400 in IDLE → PCSrc=1, branch_target=0x400. With Zero=0 → PCSrc=0.
- TIMEOUT=3, load never acked → mem_req drops after 3 WAIT cycles, err=1 and stays set, ReadData_out=0, FSM returns to IDLE.
- Assert reset=0 mid-WAIT → mem_req=0, state=IDLE and all outputs 0 immediately without a clock edge. After release, a new load completes normally.
